// File: rtl/tb_stim_pkg.sv
// Shared types and default sizes for the toggle stimulus generator and its users.
package tb_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } stim_state_t;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_PER_W     = 16;
    localparam int DEF_GUARD_CYC = 4;

endpackage

// File: rtl/toggle_stim_gen.sv
// Programmable square-wave source with edge strobes, a checker-enable window
// that opens only after a post-start guard period, and a completed-period count.
module toggle_stim_gen
    import tb_stim_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GUARD_CYC = DEF_GUARD_CYC,
    parameter int PER_W     = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    output logic             wave_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             chk_en,
    output logic             busy,
    output logic [PER_W-1:0] per_cnt
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYC > 0) ? (GUARD_CYC - 1) : 0);

    stim_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [GW-1:0]    guard_reg, guard_next;
    logic [CNT_W-1:0] high_lat_reg, high_lat_next;
    logic [CNT_W-1:0] low_lat_reg, low_lat_next;
    logic             stop_pend_reg, stop_pend_next;
    logic [PER_W-1:0] per_cnt_reg, per_cnt_next;

    logic             wave_reg, rise_reg, fall_reg, chk_reg, busy_reg;

    logic [CNT_W-1:0] high_eff, low_eff;
    logic             stop_req;

    // A zero length would make a phase vanish; clamp to a single cycle.
    assign high_eff = (high_len == '0) ? CNT_W'(1) : high_len;
    assign low_eff  = (low_len  == '0) ? CNT_W'(1) : low_len;

    assign stop_req = stop_pend_reg | stop;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        guard_next     = guard_reg;
        high_lat_next  = high_lat_reg;
        low_lat_next   = low_lat_reg;
        stop_pend_next = stop_pend_reg;
        per_cnt_next   = per_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    high_lat_next = high_eff;
                    low_lat_next  = low_eff;
                    per_cnt_next  = '0;
                    if (GUARD_CYC == 0) begin
                        state_next = LOW;
                        cnt_next   = low_eff - CNT_W'(1);
                    end else begin
                        state_next = GUARD;
                        guard_next = GUARD_LAST;
                    end
                end
            end

            GUARD: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (guard_reg == '0) begin
                    state_next = LOW;
                    cnt_next   = low_lat_reg - CNT_W'(1);
                end else begin
                    guard_next = guard_reg - GW'(1);
                end
            end

            LOW: begin
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    if (stop_req) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HIGH;
                        cnt_next   = high_lat_reg - CNT_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            HIGH: begin
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    if (per_cnt_reg != '1) begin
                        per_cnt_next = per_cnt_reg + PER_W'(1);
                    end
                    if (stop_req) begin
                        state_next = IDLE;
                    end else begin
                        state_next = LOW;
                        cnt_next   = low_lat_reg - CNT_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == IDLE) begin
            stop_pend_next = 1'b0;
        end
    end

    // Outputs decode the next state so they move on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            guard_reg     <= '0;
            high_lat_reg  <= '0;
            low_lat_reg   <= '0;
            stop_pend_reg <= 1'b0;
            per_cnt_reg   <= '0;
            wave_reg      <= 1'b0;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            chk_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            guard_reg     <= guard_next;
            high_lat_reg  <= high_lat_next;
            low_lat_reg   <= low_lat_next;
            stop_pend_reg <= stop_pend_next;
            per_cnt_reg   <= per_cnt_next;
            wave_reg      <= (state_next == HIGH);
            rise_reg      <= (state_next == HIGH) && (state_reg != HIGH);
            fall_reg      <= (state_reg == HIGH) && (state_next != HIGH);
            chk_reg       <= (state_next == LOW) || (state_next == HIGH);
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign wave_out = wave_reg;
    assign rise_stb = rise_reg;
    assign fall_stb = fall_reg;
    assign chk_en   = chk_reg;
    assign busy     = busy_reg;
    assign per_cnt  = per_cnt_reg;

endmodule

// File: doc/toggle_stim_gen.md
Name: toggle_stim_gen

Overview:
- Synthesizable stimulus source for the SVA labs: drives a periodic square wave with programmable high and low phase lengths.
- Emits a one-cycle rise strobe and a one-cycle fall strobe on every edge of the wave.
- Provides a checker-enable output. It holds edge checkers off during reset and for a guard window after start, then enables them, giving the hardware equivalent of assertoff/asserton around reset.
- Sits in front of the edge/property checkers and feeds them.

Parameters:
- CNT_W, 8, width of the phase-length inputs and phase counter.
- GUARD_CYC, 4, number of cycles chk_en stays low after start before the wave begins; 0 means no guard.
- PER_W, 16, width of the completed-period counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  single-cycle request to begin generation; sampled only in IDLE.
- stop  in  1  request to end generation at the end of the current phase.
- high_len  in  CNT_W  high-phase length in cycles; latched at start; 0 is treated as 1.
- low_len  in  CNT_W  low-phase length in cycles; latched at start; 0 is treated as 1.
- wave_out  out  1  generated waveform, registered.
- rise_stb  out  1  high for exactly the first cycle wave_out is 1 in each HIGH phase.
- fall_stb  out  1  high for exactly the first cycle wave_out is 0 after each HIGH phase.
- chk_en  out  1  checker enable; 1 only in LOW and HIGH states.
- busy  out  1  1 in any state other than IDLE.
- per_cnt  out  PER_W  number of completed HIGH phases since start; saturates at all-ones.

Behaviour:
- Reset (rst==0 at a posedge):
  - State goes to IDLE and all counters clear.
  - wave_out, rise_stb, fall_stb, chk_en, busy and per_cnt are all 0 after that edge.
  - Reset applies from any state, including mid-phase; no fall_stb is produced by reset.
- States: IDLE, GUARD, LOW, HIGH. All outputs are registered and decoded from the next state, so outputs change on the same edge as the transition.
- IDLE:
  - Outputs are 0.
  - start=1 and stop=0: latch max(high_len,1) and max(low_len,1), then go to GUARD. If GUARD_CYC==0, go straight to LOW.
  - start and stop both 1: stop wins; stay in IDLE.
  - start is ignored in every other state.
- GUARD:
  - busy=1, chk_en=0, wave_out=0.
  - Stays for exactly GUARD_CYC cycles, then goes to LOW.
  - stop=1 during GUARD goes to IDLE on the next edge.
- LOW:
  - busy=1, chk_en=1, wave_out=0.
  - Stays for latched low_len cycles, then goes to HIGH.
  - rise_stb=1 in the first HIGH cycle.
- HIGH:
  - wave_out=1.
  - Stays for latched high_len cycles.
  - Exit goes to LOW, or to IDLE if stop is pending. Either way fall_stb=1 in the following cycle and per_cnt increments on that edge.
- Stop handling:
  - stop in LOW or HIGH sets a sticky stop_pend flag.
  - The current phase completes; the design then goes to IDLE instead of the next phase.
  - Leaving HIGH for IDLE still produces fall_stb and the per_cnt increment.
  - Leaving LOW for IDLE produces no strobe.
  - stop_pend clears on entry to IDLE.
- per_cnt:
  - Clears on accepted start.
  - Holds its value in IDLE after a stop.
- Phase counter:
  - Loads len−1 on phase entry and decrements to 0.
  - The transition occurs on the edge where the count is 0.
  - Phase length is therefore exactly len cycles; a length of 1 gives single-cycle phases.
- Changing high_len or low_len while busy has no effect until the next start.

Decomposition:
- Shared package tb_stim_pkg:
  - typedef enum logic [1:0] {IDLE, GUARD, LOW, HIGH} stim_state_t.
  - Default localparams for CNT_W and PER_W.
- No sub-module: the phase counter and FSM fit in one module.

Test Plan:
- Reset, then start with GUARD_CYC=2, low_len=3, high_len=2:
  - busy=1 and chk_en=0 for 2 cycles.
  - Then wave_out 0,0,0,1,1 repeating with period 5.
  - rise_stb on every 4th cycle of each period, fall_stb on every 1st.
  - per_cnt = 3 after 3 periods.
- low_len=0, high_len=0:
  - Treated as 1, so wave_out toggles every cycle.
  - rise_stb and fall_stb alternate each cycle.
- stop asserted in the 1st cycle of HIGH (high_len=4):
  - wave_out stays 1 for all 4 cycles.
  - Then fall_stb=1, busy=0, chk_en=0.
  - per_cnt increments by 1 and then holds.
- rst=0 mid-HIGH:
  - On the next edge all outputs are 0, with no fall_stb.
  - After rst=1, start is required before any wave activity.
- start and stop asserted together in IDLE:
  - busy stays 0.
  - start alone during LOW is ignored; the latched lengths are unchanged.
- PER_W=2, run 5 periods:
  - per_cnt reads 1,2,3,3,3 (saturates).
